// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit: opcodes, ALUOp codes
// and the packed control word carried from decode into the stage registers.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001100;
    localparam logic [5:0] OP_SUBIU = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b010001;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    reg_write;
        logic    alu_src;
        logic    mem_write;
        logic    mem_read;
        logic    mem_to_reg;
        alu_op_e alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage bundle: the instruction fields offered to the control unit and the
// load-use stall it returns to the fetch side.
interface pipe_ctrl_unit_if #(
    parameter int unsigned OPCODE_W   = 6,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid_i;
    logic [OPCODE_W-1:0]   id_opcode_i;
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic [REG_ADDR_W-1:0] id_rd_i;
    logic                  hazard_stall_o;

    modport master (
        output id_valid_i, id_opcode_i, id_rs_i, id_rt_i, id_rd_i,
        input  hazard_stall_o
    );

    modport slave (
        input  id_valid_i, id_opcode_i, id_rs_i, id_rt_i, id_rd_i,
        output hazard_stall_o
    );
endinterface

// File: rtl/pipe_ctrl_unit_main_decoder.sv
// Combinational main decoder: opcode to control word, flagging undefined opcodes.
module main_decoder
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_word_t          ctrl_o,
    output logic                illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        illegal_o = 1'b0;
        case (opcode_i)
            OPCODE_W'(OP_RTYPE): begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            OPCODE_W'(OP_ADDIU): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
            end
            OPCODE_W'(OP_SUBIU): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_SUB;
            end
            OPCODE_W'(OP_SW): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
            end
            OPCODE_W'(OP_LW): begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB,
// inserts load-use bubbles and counts stalls.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W   = 6,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 2,
    parameter int unsigned CNT_W      = 16,
    parameter bit          HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze_i,
    input  logic                  flush_i,
    pipe_ctrl_unit_if.slave       id,
    output logic                  illegal_op_o,
    output logic                  ex_alu_src_o,
    output logic [ALUOP_W-1:0]    ex_alu_op_o,
    output logic                  ex_mem_read_o,
    output logic [REG_ADDR_W-1:0] ex_dst_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    output logic [REG_ADDR_W-1:0] mem_dst_o,
    output logic                  wb_reg_write_o,
    output logic                  wb_mem_to_reg_o,
    output logic [REG_ADDR_W-1:0] wb_dst_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    ctrl_word_t            dec_ctrl;
    logic                  dec_illegal;
    logic [REG_ADDR_W-1:0] dec_dst;
    logic                  hazard;
    logic                  bubble;

    logic                  ex_alu_src_q, ex_mem_read_q, ex_mem_write_q;
    logic                  ex_reg_write_q, ex_mem_to_reg_q, ex_illegal_q;
    logic [1:0]            ex_alu_op_q;
    logic [REG_ADDR_W-1:0] ex_dst_q;
    logic                  ex_alu_src_d, ex_mem_read_d, ex_mem_write_d;
    logic                  ex_reg_write_d, ex_mem_to_reg_d, ex_illegal_d;
    logic [1:0]            ex_alu_op_d;
    logic [REG_ADDR_W-1:0] ex_dst_d;

    logic                  mem_write_q, mem_read_q, mem_reg_write_q, mem_mem_to_reg_q;
    logic [REG_ADDR_W-1:0] mem_dst_q;
    logic                  wb_reg_write_q, wb_mem_to_reg_q;
    logic [REG_ADDR_W-1:0] wb_dst_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    main_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode_i  (id.id_opcode_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN && id.id_valid_i && ex_mem_read_q && (ex_dst_q != '0)) begin
            hazard = (ex_dst_q == id.id_rs_i) ||
                     ((ex_dst_q == id.id_rt_i) &&
                      ((id.id_opcode_i == OPCODE_W'(OP_RTYPE)) ||
                       (id.id_opcode_i == OPCODE_W'(OP_SW))));
        end
    end

    assign id.hazard_stall_o = hazard;
    assign bubble  = flush_i | hazard | ~id.id_valid_i;
    assign dec_dst = dec_ctrl.reg_dst ? id.id_rd_i : id.id_rt_i;

    // Bubbles and illegal opcodes both leave the zero word; only a real illegal keeps its flag.
    always_comb begin
        ex_alu_src_d    = 1'b0;
        ex_alu_op_d     = '0;
        ex_mem_read_d   = 1'b0;
        ex_mem_write_d  = 1'b0;
        ex_reg_write_d  = 1'b0;
        ex_mem_to_reg_d = 1'b0;
        ex_dst_d        = '0;
        ex_illegal_d    = 1'b0;
        if (!bubble) begin
            ex_illegal_d = dec_illegal;
            if (!dec_illegal) begin
                ex_alu_src_d    = dec_ctrl.alu_src;
                ex_alu_op_d     = dec_ctrl.alu_op;
                ex_mem_read_d   = dec_ctrl.mem_read;
                ex_mem_write_d  = dec_ctrl.mem_write;
                ex_reg_write_d  = dec_ctrl.reg_write && (dec_dst != '0);
                ex_mem_to_reg_d = dec_ctrl.mem_to_reg;
                ex_dst_d        = dec_dst;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((flush_i || hazard) && id.id_valid_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_alu_src_q     <= 1'b0;
            ex_alu_op_q      <= '0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_dst_q         <= '0;
            ex_illegal_q     <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_dst_q        <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_dst_q         <= '0;
            cnt_q            <= '0;
        end else if (!freeze_i) begin
            ex_alu_src_q     <= ex_alu_src_d;
            ex_alu_op_q      <= ex_alu_op_d;
            ex_mem_read_q    <= ex_mem_read_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_reg_write_q   <= ex_reg_write_d;
            ex_mem_to_reg_q  <= ex_mem_to_reg_d;
            ex_dst_q         <= ex_dst_d;
            ex_illegal_q     <= ex_illegal_d;
            mem_write_q      <= ex_mem_write_q;
            mem_read_q       <= ex_mem_read_q;
            mem_reg_write_q  <= ex_reg_write_q;
            mem_mem_to_reg_q <= ex_mem_to_reg_q;
            mem_dst_q        <= ex_dst_q;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_dst_q         <= mem_dst_q;
            cnt_q            <= cnt_d;
        end
    end

    assign illegal_op_o    = ex_illegal_q;
    assign ex_alu_src_o    = ex_alu_src_q;
    assign ex_alu_op_o     = ALUOP_W'(ex_alu_op_q);
    assign ex_mem_read_o   = ex_mem_read_q;
    assign ex_dst_o        = ex_dst_q;
    assign mem_write_o     = mem_write_q;
    assign mem_read_o      = mem_read_q;
    assign mem_dst_o       = mem_dst_q;
    assign wb_reg_write_o  = wb_reg_write_q;
    assign wb_mem_to_reg_o = wb_mem_to_reg_q;
    assign wb_dst_o        = wb_dst_q;
    assign stall_cnt_o     = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios then random traffic, checked against an
// instruction-level pipeline model; a second instance with a 2-bit counter checks saturation.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] R   = 6'b000100;
    localparam logic [5:0] ADI = 6'b001100;
    localparam logic [5:0] SBI = 6'b001101;
    localparam logic [5:0] SW  = 6'b010000;
    localparam logic [5:0] LW  = 6'b010001;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst, freeze, flush, v;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if if_a ();
    pipe_ctrl_unit_if if_b ();

    assign if_a.id_valid_i  = v;
    assign if_a.id_opcode_i = op;
    assign if_a.id_rs_i     = rs;
    assign if_a.id_rt_i     = rt;
    assign if_a.id_rd_i     = rd;
    assign if_b.id_valid_i  = v;
    assign if_b.id_opcode_i = op;
    assign if_b.id_rs_i     = rs;
    assign if_b.id_rt_i     = rt;
    assign if_b.id_rd_i     = rd;

    logic        a_ill, a_asrc, a_exrd, a_mw, a_mr, a_wbw, a_wbm;
    logic [1:0]  a_aop;
    logic [4:0]  a_exd, a_md, a_wbd;
    logic [15:0] a_cnt;
    logic        b_ill, b_asrc, b_exrd, b_mw, b_mr, b_wbw, b_wbm;
    logic [1:0]  b_aop;
    logic [4:0]  b_exd, b_md, b_wbd;
    logic [1:0]  b_cnt;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush), .id(if_a),
        .illegal_op_o(a_ill), .ex_alu_src_o(a_asrc), .ex_alu_op_o(a_aop),
        .ex_mem_read_o(a_exrd), .ex_dst_o(a_exd), .mem_write_o(a_mw), .mem_read_o(a_mr),
        .mem_dst_o(a_md), .wb_reg_write_o(a_wbw), .wb_mem_to_reg_o(a_wbm), .wb_dst_o(a_wbd),
        .stall_cnt_o(a_cnt)
    );

    pipe_ctrl_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush), .id(if_b),
        .illegal_op_o(b_ill), .ex_alu_src_o(b_asrc), .ex_alu_op_o(b_aop),
        .ex_mem_read_o(b_exrd), .ex_dst_o(b_exd), .mem_write_o(b_mw), .mem_read_o(b_mr),
        .mem_dst_o(b_md), .wb_reg_write_o(b_wbw), .wb_mem_to_reg_o(b_wbm), .wb_dst_o(b_wbd),
        .stall_cnt_o(b_cnt)
    );

    // One instruction occupying a pipeline slot; vld=0 is a bubble.
    typedef struct {
        bit         vld;
        logic [5:0] op;
        logic [4:0] dst;
    } rec_t;

    rec_t        m_ex, m_mem, m_wb;
    int unsigned m_stalls;

    function automatic bit legal(input logic [5:0] o);
        return o inside {R, ADI, SBI, SW, LW};
    endfunction

    function automatic bit writes_reg(input rec_t r);
        return r.vld && (r.op inside {R, ADI, SBI, LW}) && (r.dst != 0);
    endfunction

    function automatic logic [1:0] alu_op_of(input rec_t r);
        if (!r.vld) return 2'd0;
        if (r.op == R) return 2'b10;
        if (r.op == SBI) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        if (!v || !m_ex.vld || m_ex.op != LW || m_ex.dst == 0) return 1'b0;
        return (m_ex.dst == rs) || ((m_ex.dst == rt) && (op == R || op == SW));
    endfunction

    task automatic check_outputs();
        chk("ex_alu_src",    a_asrc, m_ex.vld && (m_ex.op inside {ADI, SBI, SW, LW}));
        chk("ex_alu_op",     a_aop,  alu_op_of(m_ex));
        chk("ex_mem_read",   a_exrd, m_ex.vld && m_ex.op == LW);
        chk("ex_dst",        a_exd,  m_ex.dst);
        chk("illegal_op",    a_ill,  m_ex.vld && !legal(m_ex.op));
        chk("mem_write",     a_mw,   m_mem.vld && m_mem.op == SW);
        chk("mem_read",      a_mr,   m_mem.vld && m_mem.op == LW);
        chk("mem_dst",       a_md,   m_mem.dst);
        chk("wb_reg_write",  a_wbw,  writes_reg(m_wb));
        chk("wb_mem_to_reg", a_wbm,  m_wb.vld && m_wb.op == LW);
        chk("wb_dst",        a_wbd,  m_wb.dst);
        chk("stall_cnt",     a_cnt,  (m_stalls > 65535) ? 65535 : m_stalls);
        chk("stall_cnt_sat", b_cnt,  (m_stalls > 3) ? 3 : m_stalls);
    endtask

    task automatic step(input logic r, f, fl, vv, input logic [5:0] o,
                        input logic [4:0] s, t, d);
        bit   eh;
        rec_t nw;
        @(negedge clk);
        rst = r; freeze = f; flush = fl; v = vv; op = o; rs = s; rt = t; rd = d;
        #1;
        eh = model_hazard();
        chk("hazard_stall",     if_a.hazard_stall_o, eh);
        chk("hazard_stall_sat", if_b.hazard_stall_o, eh);
        @(posedge clk);
        if (r) begin
            m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; m_wb = '{0, 0, 0}; m_stalls = 0;
        end else if (!f) begin
            if ((fl || eh) && vv) m_stalls++;
            nw = '{0, 0, 0};
            if (vv && !fl && !eh) begin
                nw.vld = 1'b1;
                nw.op  = o;
                nw.dst = !legal(o) ? 5'd0 : (o == R) ? d : t;
            end
            m_wb = m_mem; m_mem = m_ex; m_ex = nw;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [5:0] ro;
        rst = 1; freeze = 0; flush = 0; v = 0; op = 0; rs = 0; rt = 0; rd = 0;
        m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; m_wb = '{0, 0, 0}; m_stalls = 0;

        step(1, 0, 0, 1, LW, 0, 5, 0);
        step(1, 0, 0, 1, LW, 0, 5, 0);
        chk("reset_cnt_zero", a_cnt, 0);
        idle(1);

        step(0, 0, 0, 1, ADI, 1, 3, 0);
        step(0, 0, 0, 1, R,   1, 2, 7);
        idle(3);

        step(0, 0, 0, 1, LW, 0, 5, 0);
        step(0, 0, 0, 1, R,  5, 1, 9);
        chk("loaduse_cnt", a_cnt, 1);
        step(0, 0, 0, 1, R,  5, 1, 9);
        idle(3);

        step(0, 0, 0, 1, LW,  0, 0, 0);
        step(0, 0, 0, 1, R,   0, 3, 4);
        step(0, 0, 0, 1, LW,  0, 5, 0);
        step(0, 0, 0, 1, SW,  1, 5, 0);
        step(0, 0, 0, 1, SW,  1, 5, 0);
        step(0, 0, 0, 1, LW,  0, 5, 0);
        step(0, 0, 0, 1, ADI, 2, 5, 0);
        idle(3);

        step(0, 0, 0, 1, ADI, 0, 4, 0);
        step(0, 0, 0, 1, LW,  0, 6, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, R, 6, 1, 2);
        step(0, 0, 0, 1, R, 6, 1, 2);
        step(0, 0, 0, 1, R, 6, 1, 2);
        idle(3);

        step(0, 0, 0, 1, BAD, 1, 2, 3);
        chk("illegal_flag", a_ill, 1);
        idle(1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, ADI, 1, 2, 0);
        chk("sat_cnt_top", b_cnt, 3);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: ro = R;
                1: ro = ADI;
                2: ro = SBI;
                3: ro = SW;
                4: ro = LW;
                default: ro = 6'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 85), ro,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
